// File: rtl/id_exe_skid_stage.sv
// ID->EXE pipeline stage built as a two-entry skid buffer (main + skid slot).
// All outputs and in_ready come from flops; flush turns stored entries into bubbles.
module id_exe_skid_stage #(
    parameter int unsigned    PC_W     = 32,
    parameter int unsigned    CTRL_W   = 16,
    parameter int unsigned    DATA_W   = 32,
    parameter int unsigned    NUM_OPS  = 3,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W-1:0]           out_pc,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [1:0]                level
);

    localparam int unsigned OPS_W = NUM_OPS * DATA_W;

    // Encoding doubles as the stored-entry count reported on level.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [OPS_W-1:0]  m_ops_q, m_ops_d, s_ops_q, s_ops_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              up_xfer, dn_xfer;

    always_comb begin
        state_d  = state_q;
        m_pc_d   = m_pc_q;
        m_ctrl_d = m_ctrl_q;
        m_ops_d  = m_ops_q;
        s_pc_d   = s_pc_q;
        s_ctrl_d = s_ctrl_q;
        s_ops_d  = s_ops_q;
        up_xfer  = in_valid & in_ready_q;
        dn_xfer  = out_valid_q & out_ready;

        if (flush) begin
            state_d  = EMPTY;
            m_pc_d   = RESET_PC;
            m_ctrl_d = '0;
            m_ops_d  = '0;
            s_pc_d   = RESET_PC;
            s_ctrl_d = '0;
            s_ops_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_xfer) begin
                        m_pc_d   = in_pc;
                        m_ctrl_d = in_ctrl;
                        m_ops_d  = in_ops;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (dn_xfer && up_xfer) begin
                        m_pc_d   = in_pc;
                        m_ctrl_d = in_ctrl;
                        m_ops_d  = in_ops;
                    end else if (dn_xfer) begin
                        // Zeroed ctrl keeps the vacated slot a harmless bubble.
                        m_ctrl_d = '0;
                        state_d  = EMPTY;
                    end else if (up_xfer) begin
                        s_pc_d   = in_pc;
                        s_ctrl_d = in_ctrl;
                        s_ops_d  = in_ops;
                        state_d  = FULL;
                    end
                end
                FULL: begin
                    if (dn_xfer) begin
                        m_pc_d   = s_pc_q;
                        m_ctrl_d = s_ctrl_q;
                        m_ops_d  = s_ops_q;
                        s_ctrl_d = '0;
                        state_d  = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            m_pc_q      <= RESET_PC;
            m_ctrl_q    <= '0;
            m_ops_q     <= '0;
            s_pc_q      <= RESET_PC;
            s_ctrl_q    <= '0;
            s_ops_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            m_pc_q      <= m_pc_d;
            m_ctrl_q    <= m_ctrl_d;
            m_ops_q     <= m_ops_d;
            s_pc_q      <= s_pc_d;
            s_ctrl_q    <= s_ctrl_d;
            s_ops_q     <= s_ops_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = m_pc_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_ops   = m_ops_q;
    assign level     = state_q;

endmodule

// File: tb/tb_id_exe_skid_stage.sv
// Bench for id_exe_skid_stage: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_id_exe_skid_stage;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned CTRL_W   = 16;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_OPS  = 3;
    localparam logic [31:0] RST_PC   = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic [95:0] ops;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [15:0] in_ctrl;
    logic [95:0] in_ops;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [15:0] out_ctrl;
    logic [95:0] out_ops;
    logic [1:0]  level;

    id_exe_skid_stage #(
        .PC_W(PC_W),
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .NUM_OPS(NUM_OPS),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_ctrl(in_ctrl),
        .in_ops(in_ops),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_ctrl(out_ctrl),
        .out_ops(out_ops),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    ent_t mq[$];
    bit   m_rdy  = 1'b0;
    bit   clean  = 1'b0;
    bit   chk_en = 1'b0;
    int   acc    = 0;
    int   cons   = 0;
    int   fl     = 0;

    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.ctrl = {pc[7:0], 8'hA5};
        e.ops  = {pc ^ 32'hDEAD_BEEF, pc + 32'd7, ~pc};
        return e;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input logic v, input logic [31:0] pc);
        ent_t e;
        e        = mk(pc);
        in_valid = v;
        in_pc    = e.pc;
        in_ctrl  = e.ctrl;
        in_ops   = e.ops;
    endtask

    // Applies one clock edge of the rules to the queue model.
    task automatic model_update();
        bit up;
        bit dn;
        if (rst) begin
            mq.delete();
            m_rdy  = 1'b1;
            clean  = 1'b1;
            chk_en = 1'b1;
            acc    = 0;
            cons   = 0;
            fl     = 0;
        end else if (chk_en) begin
            if (flush) begin
                if (out_ready && mq.size() > 0) begin
                    void'(mq.pop_front());
                    cons++;
                end
                fl += mq.size();
                mq.delete();
                clean = 1'b1;
                m_rdy = 1'b1;
            end else begin
                up = in_valid && m_rdy;
                dn = (mq.size() > 0) && out_ready;
                if (dn) begin
                    void'(mq.pop_front());
                    cons++;
                end
                if (up) begin
                    mq.push_back(mk(in_pc));
                    acc++;
                    clean = 1'b0;
                end
                m_rdy = (mq.size() < 2);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out_valid", out_valid, (mq.size() > 0));
            chk("m_level", level, mq.size());
            chk("m_level_acct", level, acc - cons - fl);
            chk("m_in_ready", in_ready, m_rdy);
            if (mq.size() > 0) begin
                chk("m_out_pc", out_pc, mq[0].pc);
                chk("m_out_ctrl", out_ctrl, mq[0].ctrl);
                chk("m_out_ops", out_ops, mq[0].ops);
            end else begin
                chk("m_bubble_ctrl", out_ctrl, 16'h0);
                if (clean) begin
                    chk("m_clean_pc", out_pc, RST_PC);
                    chk("m_clean_ops", out_ops, 96'h0);
                end
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_ctrl"}, out_ctrl, 16'h0);
        chk({tag, "_pc"}, out_pc, RST_PC);
        chk({tag, "_ops"}, out_ops, 96'h0);
        chk({tag, "_level"}, level, 2'd0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] pcs[4];
        logic [31:0] rpc;
        ent_t        e10;

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, 32'h0);
        step();
        step();
        chk_reset_state("rst_hold");
        rst = 1'b0;

        // Reset mid-stream from FULL
        offer(1'b1, 32'h100);
        step();
        offer(1'b1, 32'h104);
        step();
        chk("full_level", level, 2'd2);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_pc", out_pc, 32'h100);
        rst = 1'b1;
        offer(1'b0, 32'h0);
        step();
        rst = 1'b0;
        chk_reset_state("rst_mid");

        // Streaming with out_ready held high
        out_ready = 1'b1;
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
        foreach (pcs[i]) begin
            offer(1'b1, pcs[i]);
            step();
            chk("stream_pc", out_pc, pcs[i]);
            chk("stream_level", level, 2'd1);
        end
        offer(1'b0, 32'h0);
        step();
        chk("stream_drain", level, 2'd0);

        // Stall absorption
        offer(1'b1, 32'h10);
        step();
        chk("stall_first", out_pc, 32'h10);
        out_ready = 1'b0;
        offer(1'b1, 32'h14);
        step();
        chk("stall_level", level, 2'd2);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_pc", out_pc, 32'h10);
        offer(1'b0, 32'h0);
        step();
        e10 = mk(32'h10);
        chk("stall_hold_pc", out_pc, 32'h10);
        chk("stall_hold_ctrl", out_ctrl, e10.ctrl);
        out_ready = 1'b1;
        step();
        chk("unstall_pc", out_pc, 32'h14);
        chk("unstall_in_ready", in_ready, 1'b1);
        chk("unstall_level", level, 2'd1);
        step();
        chk("unstall_empty", out_valid, 1'b0);

        // Flush in FULL while offering a new entry
        out_ready = 1'b0;
        offer(1'b1, 32'h20);
        step();
        offer(1'b1, 32'h24);
        step();
        chk("fl_full_level", level, 2'd2);
        flush = 1'b1;
        offer(1'b1, 32'h28);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0);
        chk_reset_state("flush_full");
        step();
        chk("flush_no28", out_valid, 1'b0);

        // Flush in ONE: input offered while in_ready=1 is still discarded
        offer(1'b1, 32'h2C);
        step();
        flush = 1'b1;
        offer(1'b1, 32'h48);
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0);
        chk_reset_state("flush_one");
        step();
        chk("flush_no48", out_valid, 1'b0);

        // Simultaneous in/out in ONE
        offer(1'b1, 32'h30);
        step();
        chk("sim_pc30", out_pc, 32'h30);
        out_ready = 1'b1;
        offer(1'b1, 32'h34);
        step();
        chk("sim_level", level, 2'd1);
        chk("sim_pc34", out_pc, 32'h34);
        offer(1'b0, 32'h0);
        step();
        chk("sim_drain", level, 2'd0);

        // rst and flush together behave as reset
        out_ready = 1'b0;
        offer(1'b1, 32'h50);
        step();
        rst   = 1'b1;
        flush = 1'b1;
        offer(1'b0, 32'h0);
        step();
        rst   = 1'b0;
        flush = 1'b0;
        chk_reset_state("rst_flush");

        // Random valid/ready/flush traffic against the model
        rpc = 32'h1000_0000;
        repeat (400) begin
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            offer(($urandom_range(0, 3) != 0), rpc);
            rpc += 32'd4;
            step();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 32'h0);
        step();
        step();
        chk("final_level", level, 2'd0);
        chk("final_in_ready", in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_exe_skid_stage.md
# id_exe_skid_stage

Parametrised ID→EXE pipeline stage that replaces the fixed, always-advancing register with a two-entry skid buffer. It adds valid/ready flow control, stall absorption and a synchronous flush that turns in-flight entries into bubbles. It sits between the decode stage (upstream producer) and the execute stage (downstream consumer). Every output is driven from a flop, and `in_ready` is registered, so no combinational path runs from `out_ready` to `in_ready`.

## Interface
Parameters:
- `PC_W`, 32, width of the instruction address carried with each entry.
- `CTRL_W`, 16, width of the packed control bundle: register write enable, data write enable, reg-select, branch ctrl and ALU ctrl.
- `DATA_W`, 32, width of one operand.
- `NUM_OPS`, 3, number of operands carried: dataA, dataB and offset.
- `RESET_PC`, 0, value of `out_pc` after reset or flush.

Ports:
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: reset, **synchronous, active-high**.
- `flush` in 1: synchronous kill of all stored entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: stage can accept an entry this cycle.
- `in_pc` in PC_W: PC of the incoming entry.
- `in_ctrl` in CTRL_W: control bundle of the incoming entry.
- `in_ops` in NUM_OPS*DATA_W: operands, with operand k at bits [k*DATA_W +: DATA_W].
- `out_valid` out 1: entry presented to execute.
- `out_ready` in 1: execute consumes the entry this cycle.
- `out_pc` out PC_W: PC of the presented entry.
- `out_ctrl` out CTRL_W: control bundle of the presented entry.
- `out_ops` out NUM_OPS*DATA_W: operands of the presented entry.
- `level` out 2: number of stored entries, 0..2.

## Operation
- Storage has two slots: main (M), which drives all `out_*` ports, and skid (S). Each slot holds pc, ctrl, ops and a valid bit.
- A transfer happens on the upstream side when `in_valid & in_ready`, and on the downstream side when `out_valid & out_ready`.
- The state machine has three states, encoded by the valid bits and reported on `level`.
- EMPTY (M invalid, S invalid, level 0):
  - With an upstream transfer, M loads the input and the state goes to ONE.
  - Otherwise the state stays EMPTY.
- ONE (M valid, S invalid, level 1):
  - Downstream and upstream transfer together: M loads the input and the state stays ONE.
  - Downstream transfer only: M is invalidated and the state goes to EMPTY.
  - Upstream transfer only: S loads the input and the state goes to FULL.
  - Neither: the state is held.
- FULL (M valid, S valid, level 2):
  - `in_ready` is 0.
  - A downstream transfer moves S into M, invalidates S and goes to ONE.
  - Otherwise the state is held.
- `in_ready` is the registered inverse of the next S-valid. It is 1 in EMPTY and ONE, and 0 in FULL.
- Bubble rule: whenever a slot is invalid, its ctrl field is all-zero. `out_ctrl` is therefore 0 whenever `out_valid` is 0, and execute never sees a spurious write enable.
- Ordering is strict FIFO. The entry held in S is always older than any entry accepted later.
- `flush` has priority over every transfer:
  - M and S are invalidated, their ctrl fields are zeroed and `out_pc` is set to RESET_PC.
  - Any input offered in the flush cycle is discarded, even if `in_ready` was 1.
  - A downstream transfer in the flush cycle still counts as consumed.
- `rst` has priority over `flush`.
- Operand values in invalid slots are don't-care, except after reset and flush, when they are 0.

## Timing
- Reset values, applied one edge after `rst`=1 is sampled:
  - `out_valid` 0, `out_pc` RESET_PC, `out_ctrl` 0, `out_ops` 0, `level` 0.
  - `in_ready` 1.
- Outputs keep their reset values for as long as `rst` is held.
- Latency is one cycle: an entry accepted at edge n appears on `out_*` after edge n.
- Throughput is one entry per cycle while `out_ready` stays 1.
- When `out_ready` drops, the stage absorbs exactly one further entry into S. `in_ready` falls after that edge. No entry is lost or duplicated.
- When `out_ready` rises in FULL, `in_ready` returns to 1 after that same edge, and S's entry is presented on the following cycle.
- After `flush` or `rst`, `in_ready` is 1 on the next cycle and accepting is legal immediately.
- `out_*` hold stable while `out_valid & ~out_ready`.
- `flush` and `rst` asserted together behave as reset.

## Test plan
- **Reset mid-stream:** fill the stage to FULL with pc 0x100 and 0x104, then assert `rst`=1 for one cycle.
  - Required next cycle: `out_valid` 0, `out_ctrl` 0, `out_pc` RESET_PC, `level` 0, `in_ready` 1.
- **Streaming:** send pc 0x0, 0x4, 0x8, 0xC back-to-back with `out_ready` held at 1.
  - Required: the same pcs leave in order, one cycle after entry, with `level` staying at 1.
- **Stall absorption:** send 0x10 and 0x14, dropping `out_ready` in the cycle 0x10 is presented.
  - Required: 0x14 lands in S, `level`=2 and `in_ready`=0, while `out_pc` stays 0x10.
  - After `out_ready` is raised: 0x10, then 0x14 are consumed, and `in_ready` returns to 1 after the first consume.
- **Flush in FULL with new input:** in FULL (0x20, 0x24), assert `flush` while offering 0x28.
  - Required: next cycle `out_valid` 0, `out_ctrl` 0 and `level` 0. Pc 0x28 never appears on the output.
- **Simultaneous in/out in ONE:** with 0x30 held in M, offer 0x34 while `out_ready`=1.
  - Required: `level` stays 1 and `out_pc` becomes 0x34.
- **Bubble check:** across random valid/ready/flush stimulus with a scoreboard, check three things every cycle.
  - `out_ctrl` is 0 whenever `out_valid` is 0.
  - Output order matches acceptance order, excluding flushed entries.
  - `level` equals accepted minus consumed minus flushed.
